// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Streams a burst of words out of a BRAM-style read port (one cycle of read
//   latency) onto a valid/ready stream. A 2-entry output FIFO decouples the
//   sink from the memory. Reads are throttled so that FIFO entries plus reads
//   in flight never exceed two, which means no returning word is ever dropped.
//
// Ports
//   clock, reset_n       single clock, asynchronous active-low reset
//   start                begin a burst (sampled only when idle)
//   base_addr, length    first word address and word count (0..2^ADDRESS_WIDTH)
//   busy                 high while a burst is in progress
//   done                 one-cycle pulse when a burst completes
//   mem_raddr, mem_dout  BRAM read port (dout valid one cycle after raddr)
//   out_valid/ready      stream handshake
//   out_data, out_last   stream payload and end-of-burst marker
//   stall_count          (only with BRAM_READER_STALL_CNT_EN) saturating count
//                        of cycles with out_valid=1 and out_ready=0
//
// Build option: define BRAM_READER_STALL_CNT_EN to add stall_count.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// RUN   | issuing reads, throttled by FIFO room
// DRAIN | all reads issued; emptying the FIFO until the out_last handshake

module bram_stream_reader #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 11
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   length,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0]    mem_dout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_last
`ifdef BRAM_READER_STALL_CNT_EN
   ,
   output logic [31:0]              stall_count
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDRESS_WIDTH:0]   LEFT_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH:0]   rd_left_q, rd_left_d;
   logic                     inflight_q, inflight_d;
   logic                     inflight_last_q, inflight_last_d;
   logic [1:0]               cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]    head_data_q, head_data_d;
   logic [DATA_WIDTH-1:0]    tail_data_q, tail_data_d;
   logic                     head_last_q, head_last_d;
   logic                     tail_last_q, tail_last_d;
   logic                     done_q, done_d;
   logic                     pop;
   logic                     issue;
   logic [2:0]               occ_sum;

   always_comb begin
      pop     = (cnt_q != 2'd0) && out_ready;
      occ_sum = {1'b0, cnt_q} + {2'b00, inflight_q};
      // A pop this cycle frees one slot, so the limit moves from 2 to 3.
      issue   = (state_q == RUN) && (rd_left_q != '0) &&
                (pop ? (occ_sum < 3'd3) : (occ_sum < 3'd2));

      state_d         = state_q;
      addr_d          = addr_q;
      rd_left_d       = rd_left_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_d   = RUN;
                  addr_d    = base_addr;
                  rd_left_d = length;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (issue) begin
               addr_d          = addr_q + ADDR_ONE;
               rd_left_d       = rd_left_q - LEFT_ONE;
               inflight_d      = 1'b1;
               inflight_last_d = (rd_left_q == LEFT_ONE);
               if (rd_left_q == LEFT_ONE) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      head_data_d = head_data_q;
      tail_data_d = tail_data_q;
      head_last_d = head_last_q;
      tail_last_d = tail_last_q;
      cnt_d       = cnt_q;
      if (pop) begin
         head_data_d = tail_data_q;
         head_last_d = tail_last_q;
         cnt_d       = cnt_q - 2'd1;
      end
      // Memory data is only meaningful the cycle after a read was issued.
      if (inflight_q) begin
         if (cnt_d == 2'd0) begin
            head_data_d = mem_dout;
            head_last_d = inflight_last_q;
         end else begin
            tail_data_d = mem_dout;
            tail_last_d = inflight_last_q;
         end
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         rd_left_q       <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         cnt_q           <= 2'd0;
         head_data_q     <= '0;
         tail_data_q     <= '0;
         head_last_q     <= 1'b0;
         tail_last_q     <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rd_left_q       <= rd_left_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         cnt_q           <= cnt_d;
         head_data_q     <= head_data_d;
         tail_data_q     <= tail_data_d;
         head_last_q     <= head_last_d;
         tail_last_q     <= tail_last_d;
         done_q          <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign mem_raddr = addr_q;
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_data_q;
   // The head flag goes stale once the head is popped, so gate it with valid.
   assign out_last  = head_last_q && (cnt_q != 2'd0);

`ifdef BRAM_READER_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == IDLE) && start) begin
         stall_d = '0;
      end else if ((cnt_q != 2'd0) && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

   localparam int DW   = 16;
   localparam int AW   = 11;
   localparam int MEMN = 1 << AW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_dout;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
`ifdef BRAM_READER_STALL_CNT_EN
   logic [31:0]   stall_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [MEMN];

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .mem_raddr (mem_raddr),
      .mem_dout  (mem_dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
`ifdef BRAM_READER_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   always #5 clock = ~clock;

   // Synchronous-read memory: dout reflects the address seen at the previous edge.
   always @(posedge clock) mem_dout <= mem[mem_raddr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},      32'(busy), 0);
      check({tag, "_done"},      32'(done), 0);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_out_last"},  32'(out_last), 0);
      check({tag, "_out_data"},  32'(out_data), 0);
      check({tag, "_mem_raddr"}, 32'(mem_raddr), 0);
   endtask

   // Called at a falling edge. Expected stream: mem[(base+i) mod 2^AW], i < len,
   // last flag on i == len-1; first beat visible 3 falling edges after start is driven.
   task automatic run_burst(input int base, input int len, input int pct,
                            input int rst_at, input bit noise);
      int k, got, stall_exp, first_k, last_hs_k, lead, limit;
      bit finished, prev_stall, exp_done, exp_busy;
      logic [DW-1:0] prev_data;
      logic          prev_last;
      start     = 1'b1;
      base_addr = AW'(base);
      length    = (AW+1)'(len);
      out_ready = ($urandom_range(99) < pct);
      @(negedge clock);
      start     = 1'b0;
      base_addr = AW'($urandom);
      length    = (AW+1)'($urandom);
      k = 1; got = 0; stall_exp = 0; first_k = 0; last_hs_k = -10;
      finished = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      limit = len * 40 + 40;
`ifdef BRAM_READER_STALL_CNT_EN
      check("stall_cleared_on_start", stall_count, 0);
`endif
      while (k < limit) begin
         exp_done = (len == 0) ? (k == 1) : ((got == len) && (k == last_hs_k + 1));
         exp_busy = (len != 0) && (got < len);
         check("done", 32'(done), 32'(exp_done));
         check("busy", 32'(busy), 32'(exp_busy));
         if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(prev_data));
            check("hold_last", 32'(out_last), 32'(prev_last));
         end
         if (busy) begin
            lead = (int'(mem_raddr) - (base + got)) & (MEMN - 1);
            check("raddr_lead_le2", 32'(lead <= 2), 1);
         end
         if (got >= len) check("no_extra_beat", 32'(out_valid), 0);
         if ((len == 0 && k == 2) || (len != 0 && got == len && k == last_hs_k + 1)) begin
            finished = 1'b1;
            start    = 1'b0;
            break;
         end
         if (rst_at >= 0 && got == rst_at && out_valid) begin
            reset_n = 1'b0;
            #1;
            check_outputs_zero("mid_reset");
            finished = 1'b1;
            start    = 1'b0;
            break;
         end
         out_ready = ($urandom_range(99) < pct);
         if (out_valid && got < len) begin
            if (first_k == 0) begin
               first_k = k;
               check("first_valid_edge", 32'(first_k), 3);
            end
            if (out_ready) begin
               check("beat_data", 32'(out_data), 32'(mem[(base + got) % MEMN]));
               check("beat_last", 32'(out_last), 32'(got == len - 1));
               if (got == len - 1) last_hs_k = k;
               got++;
            end else begin
               stall_exp++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (noise && busy && (k % 7 == 3)) begin
            start     = 1'b1;
            base_addr = AW'($urandom);
            length    = (AW+1)'($urandom_range(1, 50));
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         k++;
      end
      check("burst_completed", 32'(finished), 1);
      if (rst_at < 0) begin
         check("beat_count", 32'(got), 32'(len));
`ifdef BRAM_READER_STALL_CNT_EN
         check("stall_count", stall_count, 32'(stall_exp));
`endif
      end
   endtask

   initial begin
      int b, l, p, sel;
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b0;
      for (int i = 0; i < MEMN; i++) mem[i] = DW'(i);
      #1;
      check_outputs_zero("reset");
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      run_burst(5, 4, 100, -1, 1'b0);
      run_burst(2046, 4, 100, -1, 1'b0);
      run_burst(300, 0, 100, -1, 1'b0);
      run_burst(100, 8, 50, -1, 1'b1);
      run_burst(700, 8, 50, -1, 1'b0);

      run_burst(0, 16, 100, 2, 1'b0);
      repeat (2) @(negedge clock);
      check_outputs_zero("held_reset");
      reset_n = 1'b1;
      @(negedge clock);
      run_burst(0, 2, 100, -1, 1'b0);

      for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);
      for (int n = 0; n < 25; n++) begin
         b   = $urandom_range(MEMN - 1);
         sel = $urandom_range(5);
         l   = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 2 : $urandom_range(3, 40);
         sel = $urandom_range(2);
         p   = (sel == 0) ? 100 : (sel == 1) ? 50 : 20;
         run_burst(b, l, p, -1, 1'b1);
         if ($urandom_range(1) == 1) @(negedge clock);
      end
      run_burst($urandom_range(MEMN - 1), MEMN, 70, -1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
